riscy_mem_arbiter: RTL and testbench

- Shares the single RISCY program/data RAM between up to NREQ requesters: instruction fetch, load/store unit, and port DMA.
- Arbitrates requests and sequences the RAM control strobes (RAM_CS active-low, RAM_OE, RAM_WE) through a fixed multi-cycle access.
- Returns read data with a one-cycle ACK pulse to the winning requester.
- Sits between the sequence controller/datapath and the RAM.

---
 rtl/riscy_mem_arbiter.sv | 118 +++++++++++
 tb/tb_riscy_mem_arbiter.sv | 233 +++++++++++++++++++++++
 2 files changed

// File: rtl/riscy_mem_arbiter.sv
// riscy_mem_arbiter: shares one RAM between NREQ requesters using a fixed IDLE/ACCESS/DONE access sequence.
// Optional macro RISCY_ARB_FIXED_PRIO_EN selects fixed priority (lowest index wins); default is round-robin.
module riscy_mem_arbiter #(
   parameter int NREQ     = 3,
   parameter int AW       = 7,
   parameter int DW       = 32,
   parameter int WAIT_CYC = 1
) (
   input  logic               clk_i,
   input  logic               rst_i,
   input  logic [NREQ-1:0]    req_i,
   input  logic [NREQ-1:0]    we_i,
   input  logic [NREQ*AW-1:0] addr_i,
   input  logic [NREQ*DW-1:0] wdata_i,
   output logic [NREQ-1:0]    gnt_o,
   output logic [NREQ-1:0]    ack_o,
   output logic [DW-1:0]      rdata_o,
   output logic               ram_cs_o,
   output logic               ram_oe_o,
   output logic               ram_we_o,
   output logic [AW-1:0]      ram_addr_o,
   output logic [DW-1:0]      ram_wdata_o,
   input  logic [DW-1:0]      ram_rdata_i,
   output logic               busy_o
);
   localparam int PW = $clog2(NREQ);
   typedef enum logic [1:0] {IDLE, ACCESS, DONE} state_t;
   state_t          state_q;
   logic [3:0]      cnt_q;
   logic            we_q;
   logic [NREQ-1:0] gnt_q, ack_q;
   logic [DW-1:0]   rdata_q, wdata_q;
   logic [AW-1:0]   addr_q;
   logic            cs_q, oe_q, rwe_q;
   logic [PW-1:0]   win_d;
`ifdef RISCY_ARB_FIXED_PRIO_EN
   // lowest-index asserted request wins
   always_comb begin
      win_d = '0;
      for (int i = NREQ - 1; i >= 0; i--)
         if (req_i[i]) win_d = PW'(i);
   end
`else
   logic [PW-1:0] ptr_q, lo_d, hi_d;
   logic          hi_vld_d;
   // round-robin: first request at or above the pointer, else wrap to the lowest request
   always_comb begin
      lo_d     = '0;
      hi_d     = '0;
      hi_vld_d = 1'b0;
      for (int i = NREQ - 1; i >= 0; i--)
         if (req_i[i]) begin
            lo_d = PW'(i);
            if (PW'(i) >= ptr_q) begin
               hi_d     = PW'(i);
               hi_vld_d = 1'b1;
            end
         end
      win_d = hi_vld_d ? hi_d : lo_d;
   end
   // pointer advances past each winner at grant time
   always_ff @(posedge clk_i or posedge rst_i)
      if (rst_i) ptr_q <= '0;
      else if (state_q == IDLE && |req_i) ptr_q <= (win_d == PW'(NREQ - 1)) ? '0 : win_d + 1'b1;
`endif
   // access sequencer: latch winner in IDLE, hold strobes through ACCESS, pulse ACK in DONE
   always_ff @(posedge clk_i or posedge rst_i)
      if (rst_i) begin
         state_q <= IDLE;
         cnt_q   <= '0;
         we_q    <= 1'b0;
         gnt_q   <= '0;
         ack_q   <= '0;
         rdata_q <= '0;
         addr_q  <= '0;
         wdata_q <= '0;
         cs_q    <= 1'b1;
         oe_q    <= 1'b0;
         rwe_q   <= 1'b0;
      end else begin
         ack_q <= '0;
         case (state_q)
            IDLE:
               if (|req_i) begin
                  state_q <= ACCESS;
                  gnt_q   <= NREQ'(1) << win_d;
                  we_q    <= we_i[win_d];
                  addr_q  <= addr_i[win_d*AW +: AW];
                  wdata_q <= wdata_i[win_d*DW +: DW];
                  cnt_q   <= 4'(WAIT_CYC);
                  cs_q    <= 1'b0;
                  oe_q    <= ~we_i[win_d];
                  rwe_q   <= we_i[win_d];
               end
            ACCESS:
               if (cnt_q == '0) begin
                  state_q <= DONE;
                  ack_q   <= gnt_q;
                  gnt_q   <= '0;
                  cs_q    <= 1'b1;
                  oe_q    <= 1'b0;
                  rwe_q   <= 1'b0;
                  if (!we_q) rdata_q <= ram_rdata_i;
               end else cnt_q <= cnt_q - 1'b1;
            DONE:    state_q <= IDLE;
            default: state_q <= IDLE;
         endcase
      end
   assign gnt_o       = gnt_q;
   assign ack_o       = ack_q;
   assign rdata_o     = rdata_q;
   assign ram_cs_o    = cs_q;
   assign ram_oe_o    = oe_q;
   assign ram_we_o    = rwe_q;
   assign ram_addr_o  = addr_q;
   assign ram_wdata_o = wdata_q;
   assign busy_o      = state_q != IDLE;
endmodule

// File: tb/tb_riscy_mem_arbiter.sv
// tb_riscy_mem_arbiter: random and directed stimulus against a transaction-level model of the arbiter.
module tb_riscy_mem_arbiter;
   localparam int NREQ = 3;
   localparam int AW   = 7;
   localparam int DW   = 32;
   localparam int W    = 1;
   logic               clk_i = 1'b0;
   logic               rst_i = 1'b1;
   logic [NREQ-1:0]    req_v = '0, we_v = '0;
   logic [NREQ*AW-1:0] addr_v = '0;
   logic [NREQ*DW-1:0] wdata_v = '0;
   logic [NREQ-1:0]    gnt_o, ack_o;
   logic [DW-1:0]      rdata_o, ram_wdata_o, ram_rdata_i;
   logic               ram_cs_o, ram_oe_o, ram_we_o, busy_o;
   logic [AW-1:0]      ram_addr_o;
   logic [DW-1:0]      ram [2**AW];
   logic [DW-1:0]      ref_mem [2**AW];
   int                 n_tests = 0, n_fail = 0;
   int                 cyc = 0, t_start = 0, who = 0, ptr = 0, cur_k = 0;
   bit                 act = 0, rnd = 0;
   logic               t_we;
   logic [AW-1:0]      t_addr;
   logic [DW-1:0]      t_wd, last_rd;
   logic [NREQ-1:0]    exp_ack, obs_ack;

   riscy_mem_arbiter #(.NREQ(NREQ), .AW(AW), .DW(DW), .WAIT_CYC(W)) dut (
      .clk_i(clk_i), .rst_i(rst_i), .req_i(req_v), .we_i(we_v), .addr_i(addr_v), .wdata_i(wdata_v),
      .gnt_o(gnt_o), .ack_o(ack_o), .rdata_o(rdata_o), .ram_cs_o(ram_cs_o), .ram_oe_o(ram_oe_o),
      .ram_we_o(ram_we_o), .ram_addr_o(ram_addr_o), .ram_wdata_o(ram_wdata_o),
      .ram_rdata_i(ram_rdata_i), .busy_o(busy_o));

   always #5 clk_i = ~clk_i;

   function automatic logic [DW-1:0] seed(input int a);
      return (a == 5) ? 32'hDEADBEEF : (32'(a) * 32'h01010101) ^ 32'hA5A50000;
   endfunction

   assign ram_rdata_i = ram[ram_addr_o];
   initial begin
      for (int a = 0; a < 2**AW; a++) ram[a] = seed(a);
      forever begin
         @(posedge clk_i);
         if (!ram_cs_o && ram_we_o) ram[ram_addr_o] = ram_wdata_o;
      end
   end

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      n_tests++;
      if (obs !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, obs, exp, cyc);
      end
   endtask

   function automatic int pick(input logic [NREQ-1:0] r, input int p);
      for (int k = 0; k < NREQ; k++)
         if (r[(p + k) % NREQ]) return (p + k) % NREQ;
      return 0;
   endfunction

   task automatic new_txn(input int i);
      req_v[i] = 1'b1;
      we_v[i]  = 1'($urandom_range(0, 1));
      addr_v[i*AW +: AW]  = AW'($urandom_range(0, 15));
      wdata_v[i*DW +: DW] = $urandom;
   endtask

   task automatic drive(input logic [NREQ-1:0] ea, input int k);
      for (int i = 0; i < NREQ; i++)
         if (ea[i]) begin
            if ($urandom_range(0, 1) == 1) new_txn(i);
            else req_v[i] = 1'b0;
         end else if (!req_v[i]) begin
            if ($urandom_range(0, 3) == 0) new_txn(i);
         end else if (act && who == i && k <= W && $urandom_range(0, 7) == 0) begin
            req_v[i] = 1'b0;
            addr_v[i*AW +: AW]  = AW'($urandom);
            wdata_v[i*DW +: DW] = $urandom;
         end
   endtask

   task automatic step();
      logic [NREQ-1:0] eg, ea;
      logic [2:0]      es;
      logic            eb;
      @(posedge clk_i);
      cyc++;
      if (act) begin
         if (cyc - t_start == W + 2) act = 0;
      end else if (|req_v) begin
`ifdef RISCY_ARB_FIXED_PRIO_EN
         who = pick(req_v, 0);
`else
         who = pick(req_v, ptr);
`endif
         ptr     = (who + 1) % NREQ;
         act     = 1;
         t_start = cyc;
         t_we    = we_v[who];
         t_addr  = addr_v[who*AW +: AW];
         t_wd    = wdata_v[who*DW +: DW];
         if (t_we) ref_mem[t_addr] = t_wd;
      end
      #1;
      cur_k = cyc - t_start;
      eg = '0;
      ea = '0;
      es = 3'b100;
      eb = 1'b0;
      if (act && cur_k <= W) begin
         eg = NREQ'(1) << who;
         es = {1'b0, ~t_we, t_we};
         eb = 1'b1;
         chk("ram_addr", 64'(ram_addr_o), 64'(t_addr));
         chk("ram_wdata", 64'(ram_wdata_o), 64'(t_wd));
      end else if (act) begin
         ea = NREQ'(1) << who;
         eb = 1'b1;
         if (!t_we) last_rd = ref_mem[t_addr];
      end
      chk("gnt", 64'(gnt_o), 64'(eg));
      chk("ack", 64'(ack_o), 64'(ea));
      chk("cs_oe_we", 64'({ram_cs_o, ram_oe_o, ram_we_o}), 64'(es));
      chk("busy", 64'(busy_o), 64'(eb));
      chk("rdata", 64'(rdata_o), 64'(last_rd));
      exp_ack = ea;
      obs_ack = ack_o;
      if (rnd) drive(ea, cur_k);
   endtask

   task automatic wait_ack(input logic [NREQ-1:0] m, output int n);
      n = 0;
      do begin
         step();
         n++;
      end while ((obs_ack & m) == '0 && n < 40);
      if (n >= 40) chk("ack_timeout", 64'(obs_ack & m), 64'(m));
   endtask

   initial begin
      int n, prev;
      for (int a = 0; a < 2**AW; a++) ref_mem[a] = seed(a);
      last_rd = '0;
      exp_ack = '0;
      obs_ack = '0;
      repeat (2) @(posedge clk_i);
      #1;
      chk("rst_gnt", 64'(gnt_o), 0);
      chk("rst_ack", 64'(ack_o), 0);
      chk("rst_rdata", 64'(rdata_o), 0);
      chk("rst_strobes", 64'({ram_cs_o, ram_oe_o, ram_we_o}), 64'(3'b100));
      chk("rst_addr", 64'(ram_addr_o), 0);
      chk("rst_wdata", 64'(ram_wdata_o), 0);
      chk("rst_busy", 64'(busy_o), 0);
      rst_i = 1'b0;
      // single read of the preloaded word
      req_v = 3'b001; we_v = '0; addr_v[0 +: AW] = 7'h05;
      wait_ack(3'b001, n);
      chk("rd_latency", 64'(n), 64'(W + 2));
      chk("rd_data", 64'(rdata_o), 64'h0DEADBEEF);
      req_v = '0;
      // write by requester 1, then read back by requester 0
      req_v = 3'b010; we_v = 3'b010; addr_v[AW +: AW] = 7'h7F; wdata_v[DW +: DW] = 32'h12345678;
      wait_ack(3'b010, n);
      chk("wr_ack", 64'(obs_ack), 64'(3'b010));
      req_v = '0; we_v = '0;
      step();
      req_v = 3'b001; addr_v[0 +: AW] = 7'h7F;
      wait_ack(3'b001, n);
      chk("wr_readback", 64'(rdata_o), 64'h12345678);
      req_v = '0;
      // requester 2 withdraws in the first access cycle; the access still completes
      step();
      req_v = 3'b100; addr_v[2*AW +: AW] = 7'h09;
      step();
      req_v = '0;
      wait_ack(3'b100, n);
      chk("withdraw_ack", 64'(obs_ack), 64'(3'b100));
      step();
      chk("withdraw_idle", 64'(busy_o), 0);
      // all requesters held: check grant order and ACK spacing
      we_v = '0;
      req_v = 3'b111;
      prev = cyc;
      for (int i = 0; i < 6; i++) begin
         wait_ack(3'b111, n);
`ifdef RISCY_ARB_FIXED_PRIO_EN
         chk("prio_order", 64'(obs_ack), (i < 3) ? 64'(3'b001) : 64'(3'b010));
         if (i == 2) req_v[0] = 1'b0;
`else
         chk("rr_order", 64'(obs_ack), 64'(NREQ'(1) << (i % NREQ)));
`endif
         if (i > 0) chk("ack_spacing", 64'(cyc - prev), 64'(W + 3));
         prev = cyc;
      end
      req_v = '0;
      repeat (2) step();
      // randomized traffic
      rnd = 1;
      repeat (600) step();
      rnd = 0;
      req_v = '0;
      repeat (W + 4) step();
      // reset in the second access cycle of a write
      req_v = 3'b010; we_v = 3'b010; addr_v[AW +: AW] = 7'h33; wdata_v[DW +: DW] = 32'hCAFEF00D;
      n = 0;
      do begin
         step();
         n++;
      end while (!(act && cur_k == 1) && n < 20);
      rst_i = 1'b1;
      #1;
      chk("mid_rst_we", 64'(ram_we_o), 0);
      chk("mid_rst_cs", 64'(ram_cs_o), 1);
      chk("mid_rst_gnt", 64'(gnt_o), 0);
      chk("mid_rst_busy", 64'(busy_o), 0);
      repeat (2) begin
         @(posedge clk_i);
         #1;
         chk("mid_rst_noack", 64'(ack_o), 0);
      end
      rst_i = 1'b0;
      act = 0; ptr = 0; last_rd = '0;
      chk("post_rst_busy", 64'(busy_o), 0);
      req_v = 3'b111; we_v = '0;
      step();
      chk("post_rst_ptr", 64'(gnt_o), 64'(3'b001));
      req_v = '0;
      repeat (W + 3) step();
      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end
endmodule
